// File: rtl/data_sram_responder.sv
// Word-addressed SRAM responder with a small memory-mapped register page.
// Provides single-cycle-latency reads, lane-masked writes, a free-running
// timer, LED/scratch registers and a saturating unmapped-access counter.
module data_sram_responder #(
  parameter int          ADDR_WIDTH = 14,
  parameter logic [15:0] MMIO_PAGE  = 16'hBFAF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        sram_en,
  input  logic [3:0]  sram_wen,
  input  logic [31:0] sram_addr,
  input  logic [31:0] sram_wdata,
  output logic [31:0] sram_rdata,
  output logic [15:0] led,
  output logic [7:0]  err_cnt
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  localparam logic [15:0] OFS_LED     = 16'hF000;
  localparam logic [15:0] OFS_TIMER   = 16'hF004;
  localparam logic [15:0] OFS_SCRATCH = 16'hF008;
  localparam logic [15:0] OFS_ERRCNT  = 16'hF00C;

  // Replace only the byte lanes whose enable bit is set.
  function automatic logic [31:0] lane_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  lanes);
    logic [31:0] merged;
    merged = old_word;
    for (int i = 0; i < 4; i++) begin
      if (lanes[i]) begin
        merged[8*i +: 8] = new_word[8*i +: 8];
      end else begin
        merged[8*i +: 8] = old_word[8*i +: 8];
      end
    end
    return merged;
  endfunction

  // RAM array is intentionally left without reset.
  logic [31:0] r_mem [0:DEPTH-1];

  logic [31:0] r_rdata;
  logic [15:0] r_led;
  logic [31:0] r_timer;
  logic [31:0] r_scratch;
  logic [7:0]  r_err_cnt;

  logic [ADDR_WIDTH-1:0] w_ram_idx;
  logic [15:0] w_ofs;
  logic        w_is_mmio;
  logic        w_rd;
  logic        w_wr;
  logic        w_sel_led;
  logic        w_sel_timer;
  logic        w_sel_scratch;
  logic        w_sel_err;
  logic        w_err_hit;
  logic [31:0] w_mmio_rdata;
  logic [31:0] w_rd_word;

  assign w_ram_idx = sram_addr[ADDR_WIDTH+1:2];
  assign w_ofs     = sram_addr[15:0];
  assign w_is_mmio = (sram_addr[31:16] == MMIO_PAGE);
  assign w_rd      = sram_en & (sram_wen == 4'b0000);
  assign w_wr      = sram_en & (sram_wen != 4'b0000);

  // Address decode of the register page and read-data selection.
  always_comb begin
    w_sel_led     = w_is_mmio & (w_ofs == OFS_LED);
    w_sel_timer   = w_is_mmio & (w_ofs == OFS_TIMER);
    w_sel_scratch = w_is_mmio & (w_ofs == OFS_SCRATCH);
    w_sel_err     = w_is_mmio & (w_ofs == OFS_ERRCNT);
    // Unmapped offsets and writes to the read-only counter are both errors.
    w_err_hit     = sram_en & w_is_mmio &
                    ((~(w_sel_led | w_sel_timer | w_sel_scratch | w_sel_err)) |
                     (w_sel_err & w_wr));
    case (w_ofs)
      OFS_LED:     w_mmio_rdata = {16'h0000, r_led};
      OFS_TIMER:   w_mmio_rdata = r_timer;
      OFS_SCRATCH: w_mmio_rdata = r_scratch;
      OFS_ERRCNT:  w_mmio_rdata = {24'h000000, r_err_cnt};
      default:     w_mmio_rdata = 32'h0000_0000;
    endcase
    if (w_is_mmio) begin
      w_rd_word = w_mmio_rdata;
    end else begin
      w_rd_word = r_mem[w_ram_idx];
    end
  end

  // RAM write port: lane-masked store, RAM region only.
  always_ff @(posedge clk) begin
    if (w_wr && !w_is_mmio) begin
      r_mem[w_ram_idx] <= lane_merge(r_mem[w_ram_idx], sram_wdata, sram_wen);
    end
  end

  // Read data register: updates only on read cycles, otherwise holds.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rdata <= 32'h0000_0000;
    end else if (w_rd) begin
      r_rdata <= w_rd_word;
    end
  end

  // LED register: only the two low byte lanes are implemented.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_led <= 16'h0000;
    end else if (w_wr && w_sel_led) begin
      if (sram_wen[0]) r_led[7:0]  <= sram_wdata[7:0];
      if (sram_wen[1]) r_led[15:8] <= sram_wdata[15:8];
    end
  end

  // Free-running timer; a write replaces that cycle's increment.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_timer <= 32'h0000_0000;
    end else if (w_wr && w_sel_timer) begin
      r_timer <= lane_merge(r_timer, sram_wdata, sram_wen);
    end else begin
      r_timer <= r_timer + 32'd1;
    end
  end

  // Scratch register, lane-wise writable.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_scratch <= 32'h0000_0000;
    end else if (w_wr && w_sel_scratch) begin
      r_scratch <= lane_merge(r_scratch, sram_wdata, sram_wen);
    end
  end

  // Saturating count of bad register-page accesses.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_err_cnt <= 8'h00;
    end else if (w_err_hit && (r_err_cnt != 8'hFF)) begin
      r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign sram_rdata = r_rdata;
  assign led        = r_led;
  assign err_cnt    = r_err_cnt;

endmodule

// File: tb/tb_data_sram_responder.sv
// Directed, table-driven bench for data_sram_responder.
module tb_data_sram_responder;

  logic        clk;
  logic        resetn;
  logic        sram_en;
  logic [3:0]  sram_wen;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;
  logic [15:0] led;
  logic [7:0]  err_cnt;

  int n_pass;
  int n_total;

  typedef struct {
    logic        en;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic [15:0] exp_led;
    logic [7:0]  exp_err;
  } vec_t;

  localparam int NV = 25;
  vec_t vecs [NV];

  data_sram_responder dut (
    .clk        (clk),
    .resetn     (resetn),
    .sram_en    (sram_en),
    .sram_wen   (sram_wen),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata),
    .led        (led),
    .err_cnt    (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Drive one access and wait until just after the sampling edge.
  task automatic step(input logic en, input logic [3:0] wen,
                      input logic [31:0] addr, input logic [31:0] wdata);
    sram_en    = en;
    sram_wen   = wen;
    sram_addr  = addr;
    sram_wdata = wdata;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    resetn = 1'b0;
    sram_en = 1'b0;
    sram_wen = 4'h0;
    sram_addr = 32'h0;
    sram_wdata = 32'h0;

    //                 en   wen    addr           wdata          rdata          led       err
    vecs[0]  = '{1'b1, 4'hF, 32'h0000_0010, 32'h1122_3344, 32'h0000_0001, 16'h0000, 8'h00};
    vecs[1]  = '{1'b1, 4'h4, 32'h0000_0010, 32'h00AA_0000, 32'h0000_0001, 16'h0000, 8'h00};
    vecs[2]  = '{1'b1, 4'h0, 32'h0000_0010, 32'h0000_0000, 32'h11AA_3344, 16'h0000, 8'h00};
    vecs[3]  = '{1'b0, 4'h0, 32'h0000_0000, 32'h0000_0000, 32'h11AA_3344, 16'h0000, 8'h00};
    vecs[4]  = '{1'b0, 4'h0, 32'h0000_0000, 32'h0000_0000, 32'h11AA_3344, 16'h0000, 8'h00};
    vecs[5]  = '{1'b0, 4'h0, 32'h0000_0000, 32'h0000_0000, 32'h11AA_3344, 16'h0000, 8'h00};
    vecs[6]  = '{1'b1, 4'hF, 32'hBFAF_F000, 32'hDEAD_BEEF, 32'h11AA_3344, 16'hBEEF, 8'h00};
    vecs[7]  = '{1'b1, 4'h0, 32'hBFAF_F000, 32'h0000_0000, 32'h0000_BEEF, 16'hBEEF, 8'h00};
    vecs[8]  = '{1'b1, 4'hF, 32'hBFAF_F008, 32'hCAFE_F00D, 32'h0000_BEEF, 16'hBEEF, 8'h00};
    vecs[9]  = '{1'b1, 4'h1, 32'hBFAF_F008, 32'h0000_00AA, 32'h0000_BEEF, 16'hBEEF, 8'h00};
    vecs[10] = '{1'b1, 4'h0, 32'hBFAF_F008, 32'h0000_0000, 32'hCAFE_F0AA, 16'hBEEF, 8'h00};
    vecs[11] = '{1'b1, 4'hC, 32'hBFAF_F000, 32'h1234_5678, 32'hCAFE_F0AA, 16'hBEEF, 8'h00};
    vecs[12] = '{1'b1, 4'h2, 32'hBFAF_F000, 32'h0000_5500, 32'hCAFE_F0AA, 16'h55EF, 8'h00};
    vecs[13] = '{1'b1, 4'h0, 32'hBFAF_F000, 32'h0000_0000, 32'h0000_55EF, 16'h55EF, 8'h00};
    vecs[14] = '{1'b0, 4'hF, 32'h0000_0010, 32'hFFFF_FFFF, 32'h0000_55EF, 16'h55EF, 8'h00};
    vecs[15] = '{1'b1, 4'h0, 32'h0000_0010, 32'h0000_0000, 32'h11AA_3344, 16'h55EF, 8'h00};
    vecs[16] = '{1'b1, 4'h0, 32'h0001_0010, 32'h0000_0000, 32'h11AA_3344, 16'h55EF, 8'h00};
    vecs[17] = '{1'b1, 4'hF, 32'h0000_0014, 32'h0102_0304, 32'h11AA_3344, 16'h55EF, 8'h00};
    vecs[18] = '{1'b1, 4'h0, 32'h0000_0014, 32'h0000_0000, 32'h0102_0304, 16'h55EF, 8'h00};
    vecs[19] = '{1'b1, 4'h0, 32'hBFAF_F00C, 32'h0000_0000, 32'h0000_0000, 16'h55EF, 8'h00};
    vecs[20] = '{1'b1, 4'h0, 32'hBFAF_F010, 32'h0000_0000, 32'h0000_0000, 16'h55EF, 8'h01};
    vecs[21] = '{1'b1, 4'hF, 32'hBFAF_F00C, 32'hFFFF_FFFF, 32'h0000_0000, 16'h55EF, 8'h02};
    vecs[22] = '{1'b1, 4'h0, 32'hBFAF_F00C, 32'h0000_0000, 32'h0000_0002, 16'h55EF, 8'h02};
    vecs[23] = '{1'b1, 4'hF, 32'hBFAE_F000, 32'h0000_0077, 32'h0000_0002, 16'h55EF, 8'h02};
    vecs[24] = '{1'b1, 4'h0, 32'h0000_F000, 32'h0000_0000, 32'h0000_0077, 16'h55EF, 8'h02};

    // Reset values while resetn is low.
    #2;
    chk("reset_rdata", sram_rdata, 32'h0);
    chk("reset_led", {16'h0, led}, 32'h0);
    chk("reset_err", {24'h0, err_cnt}, 32'h0);

    // Timer reads across reset release: first edge sees 0, next sees 1.
    sram_en = 1'b1;
    sram_wen = 4'h0;
    sram_addr = 32'hBFAF_F004;
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    chk("timer_first", sram_rdata, 32'h0000_0000);
    @(posedge clk);
    #1;
    chk("timer_second", sram_rdata, 32'h0000_0001);

    // Table-driven main function.
    for (int i = 0; i < NV; i++) begin
      step(vecs[i].en, vecs[i].wen, vecs[i].addr, vecs[i].wdata);
      chk($sformatf("vec%0d_rdata", i), sram_rdata, vecs[i].exp_rdata);
      chk($sformatf("vec%0d_led", i), {16'h0, led}, {16'h0, vecs[i].exp_led});
      chk($sformatf("vec%0d_err", i), {24'h0, err_cnt}, {24'h0, vecs[i].exp_err});
    end

    // Timer load and wrap.
    step(1'b1, 4'hF, 32'hBFAF_F004, 32'hFFFF_FFFE);
    step(1'b1, 4'h0, 32'hBFAF_F004, 32'h0);
    chk("timer_wr_n1", sram_rdata, 32'hFFFF_FFFE);
    step(1'b1, 4'h0, 32'hBFAF_F004, 32'h0);
    chk("timer_wr_n2", sram_rdata, 32'hFFFF_FFFF);
    step(1'b1, 4'h0, 32'hBFAF_F004, 32'h0);
    chk("timer_wrap", sram_rdata, 32'h0000_0000);
    // Held value is 1 here; merge low two lanes only.
    step(1'b1, 4'h3, 32'hBFAF_F004, 32'hAAAA_1234);
    step(1'b1, 4'h0, 32'hBFAF_F004, 32'h0);
    chk("timer_lane", sram_rdata, 32'h0000_1234);
    step(1'b1, 4'h0, 32'hBFAF_F004, 32'h0);
    chk("timer_resume", sram_rdata, 32'h0000_1235);

    // Error counter saturation; counter is at 2 here.
    for (int i = 0; i < 300; i++) begin
      step(1'b1, 4'h0, 32'hBFAF_F100, 32'h0);
      chk($sformatf("unmapped_rd%0d", i), sram_rdata, 32'h0);
      chk($sformatf("errcnt%0d", i), {24'h0, err_cnt},
          (i + 3 > 255) ? 32'd255 : 32'(i + 3));
    end
    step(1'b1, 4'h0, 32'hBFAF_F00C, 32'h0);
    chk("errcnt_reg", sram_rdata, 32'h0000_00FF);

    // Reset during a pending read.
    step(1'b1, 4'hF, 32'h0000_0020, 32'h5A5A_5A5A);
    sram_en = 1'b1;
    sram_wen = 4'h0;
    sram_addr = 32'h0000_0020;
    #2;
    resetn = 1'b0;
    #1;
    chk("async_rst_rdata", sram_rdata, 32'h0);
    chk("async_rst_led", {16'h0, led}, 32'h0);
    chk("async_rst_err", {24'h0, err_cnt}, 32'h0);
    @(posedge clk);
    #1;
    chk("rst_hold_rdata", sram_rdata, 32'h0);
    @(negedge clk);
    sram_en = 1'b0;
    resetn = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_release_rdata", sram_rdata, 32'h0);
    step(1'b1, 4'h0, 32'hBFAF_F008, 32'h0);
    chk("rst_scratch", sram_rdata, 32'h0);
    step(1'b1, 4'h0, 32'h0000_0020, 32'h0);
    chk("ram_survives_rst", sram_rdata, 32'h5A5A_5A5A);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
